// File: rtl/gate_op_pkg.sv
// Shared types and constants for the gate-op arbiter slice.
package gate_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/gate_op_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module gate_op_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin shared bitwise logic unit (AND/OR/XOR/NAND) with a tagged response port.
// Define GATE_OP_STATS_EN to add per-requester saturating grant counters on grant_cnt.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_y
`ifdef GATE_OP_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt
`endif
);

  state_e              state, state_next;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;
  logic                accept;
  logic [ID_W-1:0]     rr_ptr;
  logic [DATA_W-1:0]   a_q, b_q, exec_y;
  op_e                 op_q;
  logic [ID_W-1:0]     id_q;

  gate_op_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign accept = (state == ST_IDLE) && any_valid;

  // req_ready is masked during reset so no handshake can complete while rst_n is low
  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      ST_IDLE: begin
        if (any_valid && rst_n) begin
          req_ready  = grant;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    exec_y = '0;
    unique case (op_q)
      OP_AND:  exec_y = a_q & b_q;
      OP_OR:   exec_y = a_q | b_q;
      OP_XOR:  exec_y = a_q ^ b_q;
      OP_NAND: exec_y = ~(a_q & b_q);
      default: exec_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q  <= req_a[grant_idx*DATA_W +: DATA_W];
        b_q  <= req_b[grant_idx*DATA_W +: DATA_W];
        op_q <= op_e'(req_op[grant_idx*2 +: 2]);
        id_q <= grant_idx;
        if (int'(grant_idx) == NUM_REQ - 1) rr_ptr <= '0;
        else                                rr_ptr <= grant_idx + ID_W'(1);
      end
      if (state == ST_EXEC) begin
        rsp_y     <= exec_y;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state == ST_RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef GATE_OP_STATS_EN
  localparam logic [STATS_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && grant_cnt[i*STATS_W +: STATS_W] != CNT_MAX)
          grant_cnt[i*STATS_W +: STATS_W] <= grant_cnt[i*STATS_W +: STATS_W] + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter: single ops, all opcodes, round robin, backpressure, reset.
module tb_gate_op_arbiter;
  import gate_op_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;
`ifdef GATE_OP_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] rr_y [4] = '{8'h42, 8'hDB, 8'h99, 8'hBD};

  gate_op_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
`ifdef GATE_OP_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op);
    req_valid[idx]      = 1'b1;
    req_a[idx*8 +: 8]   = a;
    req_b[idx*8 +: 8]   = b;
    req_op[idx*2 +: 2]  = op;
  endtask

  task automatic dropRequest(input int idx);
    req_valid[idx] = 1'b0;
  endtask

  // Called in an IDLE cycle with rsp_ready high and no other requester valid
  task automatic runOp(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp_y);
    applyStimulus(idx, a, b, op);
    #1;
    checkOutput("op_grant", 64'(req_ready), 64'(32'd1 << idx));
    tick();
    dropRequest(idx);
    checkOutput("op_exec_ready", 64'(req_ready), 64'd0);
    checkOutput("op_exec_valid", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("op_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("op_rsp_y", 64'(rsp_y), 64'(exp_y));
    checkOutput("op_rsp_id", 64'(rsp_id), 64'(idx));
    tick();
    checkOutput("op_rsp_clear", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    tick();
    tick();

    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_rsp_y", 64'(rsp_y), 64'd0);
    checkOutput("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    req_valid = 4'b0001;
    #1;
    checkOutput("rst_masked_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    $display("[TB] single op and opcode sweep");
    rsp_ready = 1'b1;
    runOp(0, 8'hF0, 8'h3C, 2'b00, 8'h30);
    runOp(2, 8'hA5, 8'h0F, 2'b00, 8'h05);
    runOp(2, 8'hA5, 8'h0F, 2'b01, 8'hAF);
    runOp(2, 8'hA5, 8'h0F, 2'b10, 8'hAA);
    runOp(2, 8'hA5, 8'h0F, 2'b11, 8'hFA);

    $display("[TB] round robin with all requesters valid");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 8'hC3, 8'h5A, 2'b00);
    applyStimulus(1, 8'hC3, 8'h5A, 2'b01);
    applyStimulus(2, 8'hC3, 8'h5A, 2'b10);
    applyStimulus(3, 8'hC3, 8'h5A, 2'b11);
    for (int g = 0; g < 5; g++) begin
      #1;
      checkOutput("rr_grant", 64'(req_ready), 64'(32'd1 << (g % 4)));
      tick();
      checkOutput("rr_exec_ready", 64'(req_ready), 64'd0);
      tick();
      checkOutput("rr_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("rr_rsp_y", 64'(rsp_y), 64'(rr_y[g % 4]));
      checkOutput("rr_rsp_id", 64'(rsp_id), 64'(g % 4));
      checkOutput("rr_resp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    #1;
    checkOutput("rr_next_grant", 64'(req_ready), 64'd2);
    checkOutput("rr_ptr_wrap", 64'(dut.rr_ptr), 64'd1);
    req_valid = '0;
    #1;

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(0, 8'hF0, 8'h3C, 2'b00);
    #1;
    checkOutput("bp_grant", 64'(req_ready), 64'd1);
    tick();
    dropRequest(0);
    applyStimulus(1, 8'h0F, 8'hF0, 2'b10);
    tick();
    checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("bp_rsp_y", 64'(rsp_y), 64'h30);
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput("bp_hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_hold_y", 64'(rsp_y), 64'h30);
      checkOutput("bp_hold_id", 64'(rsp_id), 64'd0);
      checkOutput("bp_hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_hs_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("bp_idle_valid", 64'(rsp_valid), 64'd0);
    checkOutput("bp_next_grant", 64'(req_ready), 64'd2);
    tick();
    dropRequest(1);
    tick();
    checkOutput("bp_req1_y", 64'(rsp_y), 64'hFF);
    checkOutput("bp_req1_id", 64'(rsp_id), 64'd1);
    tick();

    $display("[TB] reset during execution");
    applyStimulus(1, 8'hFF, 8'h0F, 2'b11);
    #1;
    checkOutput("mr_grant", 64'(req_ready), 64'd2);
    tick();
    applyStimulus(3, 8'h11, 8'h22, 2'b01);
    rst_n = 1'b0;
    tick();
    checkOutput("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mr_req_ready", 64'(req_ready), 64'd0);
    checkOutput("mr_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    checkOutput("mr_state", 64'(dut.state), 64'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    checkOutput("mr_first_grant", 64'(req_ready), 64'd2);
    tick();
    dropRequest(1);
    tick();
    checkOutput("mr_req1_valid", 64'(rsp_valid), 64'd1);
    checkOutput("mr_req1_y", 64'(rsp_y), 64'hF0);
    checkOutput("mr_req1_id", 64'(rsp_id), 64'd1);
    tick();
    checkOutput("mr_second_grant", 64'(req_ready), 64'd8);
    tick();
    dropRequest(3);
    tick();
    checkOutput("mr_req3_y", 64'(rsp_y), 64'h33);
    checkOutput("mr_req3_id", 64'(rsp_id), 64'd3);
    tick();

`ifdef GATE_OP_STATS_EN
    $display("[TB] grant statistics");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("stats_reset", grant_cnt, 64'd0);
    runOp(1, 8'h01, 8'h02, 2'b01, 8'h03);
    runOp(1, 8'h01, 8'h02, 2'b01, 8'h03);
    runOp(1, 8'h01, 8'h02, 2'b01, 8'h03);
    runOp(3, 8'hFF, 8'hFF, 2'b10, 8'h00);
    checkOutput("stats_counts", grant_cnt, {16'd1, 16'd0, 16'd3, 16'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
